exec_arbiter: RTL and testbench

Two-requester arbiter and result stage for the single shared ALU (`Executor`) in the uarch core. It accepts operations from the integer issue path (requester 0) and the branch-compare path (requester 1) over valid/ready handshakes. Each cycle it grants the ALU to one requester using round-robin priority and registers the result with its tag and source ID. It presents the result to writeback over a valid/ready handshake with full backpressure.

---
 rtl/exec_arbiter_pkg.sv | 37 +++
 rtl/exec_arbiter_executor.sv | 35 +++
 rtl/exec_arbiter.sv | 125 ++++++++++++
 tb/tb_exec_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/exec_arbiter_pkg.sv
// ============================================================================
// exec_arbiter_pkg : shared ALU encodings, request record and round-robin pick
// Revision: 1.0
// ============================================================================
`default_nettype none

package exec_arbiter_pkg;

  localparam logic       DECODER_ALU_SRC2_REG = 1'b0;
  localparam logic       DECODER_ALU_SRC2_IMM = 1'b1;

  localparam logic [2:0] DECODER_ALU_OP_ADD   = 3'd0;
  localparam logic [2:0] DECODER_ALU_OP_SUB   = 3'd1;
  localparam logic [2:0] DECODER_ALU_OP_BEQ   = 3'd2;
  localparam logic [2:0] DECODER_ALU_OP_BNE   = 3'd3;

  localparam logic       EXEC_ARB_SRC_INT     = 1'b0;
  localparam logic       EXEC_ARB_SRC_BR      = 1'b1;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        src2;
    logic [2:0]  op;
  } alu_req_t;

  // With both valid, the requester not granted most recently wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    if (v1)       return EXEC_ARB_SRC_BR;
    return EXEC_ARB_SRC_INT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_arbiter_executor.sv
// ============================================================================
// exec_arbiter_executor : combinational 32-bit ALU shared by both requesters
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_arbiter_executor
  import exec_arbiter_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm,
  input  logic        sig_src2,
  input  logic [2:0]  sig_op,
  output logic [31:0] result
);

  logic [31:0] w_src2;

  always_comb begin
    w_src2 = (sig_src2 == DECODER_ALU_SRC2_IMM) ? imm : rs2;
    // Unknown opcodes produce zero rather than any leftover value.
    result = 32'h0;
    case (sig_op)
      DECODER_ALU_OP_ADD: result = rs1 + w_src2;
      DECODER_ALU_OP_SUB: result = rs1 - w_src2;
      DECODER_ALU_OP_BEQ: result = {31'b0, (rs1 == w_src2)};
      DECODER_ALU_OP_BNE: result = {31'b0, (rs1 != w_src2)};
      default:            result = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exec_arbiter.sv
// ============================================================================
// exec_arbiter : round-robin arbiter for two ALU requesters, one-entry
//                registered result stage with full backpressure
// Revision: 1.0
// ============================================================================
`default_nettype none

module exec_arbiter
  import exec_arbiter_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             _clk,
  input  logic             _rst_n,
  input  logic             _req0_valid,
  input  logic [31:0]      _req0_rs1,
  input  logic [31:0]      _req0_rs2,
  input  logic [31:0]      _req0_imm,
  input  logic             _req0_sig_src2,
  input  logic [2:0]       _req0_sig_op,
  input  logic [TAG_W-1:0] _req0_tag,
  input  logic             _req1_valid,
  input  logic [31:0]      _req1_rs1,
  input  logic [31:0]      _req1_rs2,
  input  logic [31:0]      _req1_imm,
  input  logic             _req1_sig_src2,
  input  logic [2:0]       _req1_sig_op,
  input  logic [TAG_W-1:0] _req1_tag,
  output logic             req0_ready_,
  output logic             req1_ready_,
  output logic             res_valid_,
  input  logic             _res_ready,
  output logic [31:0]      res_,
  output logic [TAG_W-1:0] res_tag_,
  output logic             res_src_
);

  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_q, res_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_src_q, res_src_d;
  logic             last_grant_q, last_grant_d;

  logic             w_can_accept;
  logic             w_grant;
  logic             w_sel_valid;
  logic             w_xfer;
  alu_req_t         w_sel_req;
  logic [TAG_W-1:0] w_sel_tag;
  logic [31:0]      w_alu_res;

  always_comb begin
    w_can_accept = !res_valid_q || _res_ready;
    w_grant      = rr_pick(_req0_valid, _req1_valid, last_grant_q);

    if (w_grant == EXEC_ARB_SRC_BR) begin
      w_sel_valid = _req1_valid;
      w_sel_tag   = _req1_tag;
      w_sel_req   = '{rs1: _req1_rs1, rs2: _req1_rs2, imm: _req1_imm,
                      src2: _req1_sig_src2, op: _req1_sig_op};
    end else begin
      w_sel_valid = _req0_valid;
      w_sel_tag   = _req0_tag;
      w_sel_req   = '{rs1: _req0_rs1, rs2: _req0_rs2, imm: _req0_imm,
                      src2: _req0_sig_src2, op: _req0_sig_op};
    end

    w_xfer = w_can_accept && w_sel_valid;

    // Gated by reset so neither requester sees a handshake while held in reset.
    req0_ready_ = _rst_n && w_can_accept && (w_grant == EXEC_ARB_SRC_INT);
    req1_ready_ = _rst_n && w_can_accept && (w_grant == EXEC_ARB_SRC_BR);
  end

  exec_arbiter_executor u_executor (
    .rs1      (w_sel_req.rs1),
    .rs2      (w_sel_req.rs2),
    .imm      (w_sel_req.imm),
    .sig_src2 (w_sel_req.src2),
    .sig_op   (w_sel_req.op),
    .result   (w_alu_res)
  );

  always_comb begin
    res_valid_d  = res_valid_q;
    res_d        = res_q;
    res_tag_d    = res_tag_q;
    res_src_d    = res_src_q;
    last_grant_d = last_grant_q;

    if (w_xfer) begin
      res_valid_d  = 1'b1;
      res_d        = w_alu_res;
      res_tag_d    = w_sel_tag;
      res_src_d    = w_grant;
      last_grant_d = w_grant;
    end else if (_res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge _clk or negedge _rst_n) begin
    if (!_rst_n) begin
      res_valid_q  <= 1'b0;
      res_q        <= 32'h0;
      res_tag_q    <= '0;
      res_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      res_valid_q  <= res_valid_d;
      res_q        <= res_d;
      res_tag_q    <= res_tag_d;
      res_src_q    <= res_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid_ = res_valid_q;
  assign res_       = res_q;
  assign res_tag_   = res_tag_q;
  assign res_src_   = res_src_q;

endmodule

`default_nettype wire

// File: tb/tb_exec_arbiter.sv
// ============================================================================
// tb_exec_arbiter : directed vector table plus reset corner sequences
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exec_arbiter;
  import exec_arbiter_pkg::*;

  typedef struct packed {
    logic        v;
    logic [2:0]  op;
    logic        s2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [4:0]  t;
  } rq_t;

  typedef struct packed {
    rq_t         r0;
    rq_t         r1;
    logic        rr;
    logic        er0;
    logic        er1;
    logic        erv;
    logic [31:0] eres;
    logic [4:0]  etag;
    logic        esrc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  rq_t         q0, q1;
  logic        res_ready;
  logic        rdy0, rdy1, rv, rsrc;
  logic [31:0] res;
  logic [4:0]  rtag;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  exec_arbiter #(.TAG_W(5)) dut (
    ._clk           (clk),
    ._rst_n         (rst_n),
    ._req0_valid    (q0.v),
    ._req0_rs1      (q0.a),
    ._req0_rs2      (q0.b),
    ._req0_imm      (q0.i),
    ._req0_sig_src2 (q0.s2),
    ._req0_sig_op   (q0.op),
    ._req0_tag      (q0.t),
    ._req1_valid    (q1.v),
    ._req1_rs1      (q1.a),
    ._req1_rs2      (q1.b),
    ._req1_imm      (q1.i),
    ._req1_sig_src2 (q1.s2),
    ._req1_sig_op   (q1.op),
    ._req1_tag      (q1.t),
    .req0_ready_    (rdy0),
    .req1_ready_    (rdy1),
    .res_valid_     (rv),
    ._res_ready     (res_ready),
    .res_           (res),
    .res_tag_       (rtag),
    .res_src_       (rsrc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rq_t mk(input logic [2:0] op, input logic s2, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] i, input logic [4:0] t);
    return '{v: 1'b1, op: op, s2: s2, a: a, b: b, i: i, t: t};
  endfunction

  function automatic vec_t mv(input rq_t r0, input rq_t r1, input logic rr,
                              input logic er0, input logic er1, input logic erv,
                              input logic [31:0] eres, input logic [4:0] etag, input logic esrc);
    return '{r0: r0, r1: r1, rr: rr, er0: er0, er1: er1, erv: erv,
             eres: eres, etag: etag, esrc: esrc};
  endfunction

  task automatic chk_res(input string tag, input logic erv, input logic [31:0] eres,
                         input logic [4:0] etag, input logic esrc);
    chk({tag, " res_valid"}, {31'b0, rv}, {31'b0, erv});
    chk({tag, " res"}, res, eres);
    chk({tag, " res_tag"}, {27'b0, rtag}, {27'b0, etag});
    chk({tag, " res_src"}, {31'b0, rsrc}, {31'b0, esrc});
  endtask

  initial begin
    rq_t idle, sub0, beq1, add0, addr0, bad1, subi0, bne1, bne1e, wrap0;
    idle  = '0;
    sub0  = mk(DECODER_ALU_OP_SUB, DECODER_ALU_SRC2_REG, 32'd3, 32'd5, 32'd0, 5'd1);
    beq1  = mk(DECODER_ALU_OP_BEQ, DECODER_ALU_SRC2_REG, 32'd9, 32'd9, 32'd0, 5'd2);
    add0  = mk(DECODER_ALU_OP_ADD, DECODER_ALU_SRC2_IMM, 32'd5, 32'd0, 32'd7, 5'd3);
    addr0 = mk(DECODER_ALU_OP_ADD, DECODER_ALU_SRC2_REG, 32'd100, 32'd23, 32'd999, 5'd4);
    bad1  = mk(3'b111, DECODER_ALU_SRC2_REG, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 5'd7);
    subi0 = mk(DECODER_ALU_OP_SUB, DECODER_ALU_SRC2_IMM, 32'd10, 32'd50, 32'd3, 5'd9);
    bne1  = mk(DECODER_ALU_OP_BNE, DECODER_ALU_SRC2_REG, 32'd4, 32'd9, 32'd0, 5'd8);
    bne1e = mk(DECODER_ALU_OP_BNE, DECODER_ALU_SRC2_REG, 32'd6, 32'd6, 32'd0, 5'd10);
    wrap0 = mk(DECODER_ALU_OP_ADD, DECODER_ALU_SRC2_REG, 32'hFFFFFFFF, 32'd2, 32'd0, 5'd11);

    // Contention straight out of reset: 0,1,0,1
    vecs.push_back(mv(sub0, beq1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 5'd1, 1'b0));
    vecs.push_back(mv(sub0, beq1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 5'd2, 1'b1));
    vecs.push_back(mv(sub0, beq1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFE, 5'd1, 1'b0));
    vecs.push_back(mv(sub0, beq1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 5'd2, 1'b1));
    // Single ADD-immediate
    vecs.push_back(mv(add0, idle, 1'b1, 1'b1, 1'b0, 1'b1, 32'd12, 5'd3, 1'b0));
    // Backpressure for 3 cycles, then release with same-cycle transfer
    vecs.push_back(mv(addr0, idle, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 5'd3, 1'b0));
    vecs.push_back(mv(addr0, idle, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 5'd3, 1'b0));
    vecs.push_back(mv(addr0, idle, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 5'd3, 1'b0));
    vecs.push_back(mv(addr0, idle, 1'b1, 1'b1, 1'b0, 1'b1, 32'd123, 5'd4, 1'b0));
    // Drain with no new op: valid drops, data holds
    vecs.push_back(mv(idle, idle, 1'b1, 1'b1, 1'b0, 1'b0, 32'd123, 5'd4, 1'b0));
    // Undefined op from requester 1
    vecs.push_back(mv(idle, bad1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd7, 1'b1));
    // Contention after last grant went to 1
    vecs.push_back(mv(subi0, bne1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd7, 5'd9, 1'b0));
    vecs.push_back(mv(subi0, bne1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 5'd8, 1'b1));
    vecs.push_back(mv(idle, bne1e, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd10, 1'b1));
    vecs.push_back(mv(wrap0, idle, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 5'd11, 1'b0));

    // Reset state with both requesters asserting
    q0 = sub0; q1 = beq1; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst ready0", {31'b0, rdy0}, 32'd0);
    chk("rst ready1", {31'b0, rdy1}, 32'd0);
    chk_res("rst", 1'b0, 32'h0, 5'd0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      q0 = vecs[k].r0; q1 = vecs[k].r1; res_ready = vecs[k].rr;
      #1;
      chk($sformatf("v%0d ready0", k), {31'b0, rdy0}, {31'b0, vecs[k].er0});
      chk($sformatf("v%0d ready1", k), {31'b0, rdy1}, {31'b0, vecs[k].er1});
      @(posedge clk); #1;
      chk_res($sformatf("v%0d", k), vecs[k].erv, vecs[k].eres, vecs[k].etag, vecs[k].esrc);
      @(negedge clk);
    end

    // Reset mid-flight while the result is stalled
    q0 = add0; q1 = idle; res_ready = 1'b1;
    @(posedge clk); #1;
    chk_res("mf load", 1'b1, 32'd12, 5'd3, 1'b0);
    @(negedge clk);
    q0 = idle; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_res("mf rst", 1'b0, 32'h0, 5'd0, 1'b0);
    chk("mf ready0", {31'b0, rdy0}, 32'd0);
    chk("mf ready1", {31'b0, rdy1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_res("mf after", 1'b0, 32'h0, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
